// File: rtl/dm_be_mem.sv
// Byte-enabled word RAM for the core's load/store path: sb/sh/sw merge, lb/lbu/lh/lhu/lw
// extension, registered one-cycle response with alignment/range flags and a post-reset clear sweep.
module dm_be_mem #(
  parameter int          ADDR_BITS      = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        exc_align,
  output logic        exc_range,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] clr_ptr;
  logic [31:0]          mem [DEPTH];

  logic [31:0]          off;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           lane;
  logic                 range_err, align_err, fault, accept, do_store;
  logic [31:0]          old_word, merged_word;

  logic                 vld_p1, exc_align_p1, exc_range_p1;
  logic [31:0]          rdata_p1;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] ln);
    case (size)
      2'd0:    return 4'b0001 << ln;
      2'd1:    return 4'b0011 << ln;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction

  // Word is shifted so the addressed lane sits at bit 0; aligned halves only land at lane 0 or 2.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] ln,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {ln, 3'b000};
    case (size)
      2'd0:    return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign off       = addr - BASE_ADDR;
  assign idx       = off[ADDR_BITS+1:2];
  assign lane      = off[1:0];
  assign range_err = |off[31:ADDR_BITS+2];
  assign align_err = (req_size == 2'd3) || (req_size == 2'd1 && lane[0]) ||
                     (req_size == 2'd2 && lane != 2'd0);
  assign fault     = range_err | align_err;
  assign accept    = req_valid & req_ready;
  assign do_store  = accept & req_we & ~fault & reset;

  assign old_word    = mem[idx];
  assign merged_word = merge(old_word, replicate(req_size, wdata), lane_enables(req_size, lane));

  assign busy      = (state == S_CLEAR);
  assign req_ready = (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_ptr == '1)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR)
        clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // RAM: sweep and store share the single write port; a store never overlaps the sweep.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[clr_ptr] <= '0;
    else if (do_store)
      mem[idx] <= merged_word;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (do_store)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
  end
`endif

  // Stage p1: registered response, one cycle after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      rdata_p1     <= '0;
      exc_align_p1 <= 1'b0;
      exc_range_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        exc_align_p1 <= align_err;
        exc_range_p1 <= range_err;
        rdata_p1     <= (fault || req_we) ? 32'h0
                                          : extend(old_word, lane, req_size, req_unsigned);
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rdata     = rdata_p1;
  assign exc_align = exc_align_p1;
  assign exc_range = exc_range_p1;

endmodule

// File: tb/tb_dm_be_mem.sv
// Directed bench for dm_be_mem: clear sweep timing, byte/half merge, load extension,
// exception flags, back-to-back store/load and reset during the sweep.
module tb_dm_be_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata, pc;
  logic        rsp_valid, exc_align, exc_range, busy;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  dm_be_mem dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .addr(addr), .wdata(wdata), .pc(pc), .rsp_valid(rsp_valid), .rdata(rdata),
    .exc_align(exc_align), .exc_range(exc_range), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_align;
    logic        exp_range;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] er, logic ea, logic eg);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.uns = uns; v.a = a; v.wd = wd;
    v.exp_rdata = er; v.exp_align = ea; v.exp_range = eg;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    addr = v.a; wdata = v.wd; pc = 32'h1000 + v.a;
  endtask

  task automatic issue(vec_t v);
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({v.name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({v.name, ".rdata"}, rdata, v.exp_rdata);
    chk({v.name, ".exc_align"}, 32'(exc_align), 32'(v.exp_align));
    chk({v.name, ".exc_range"}, 32'(exc_range), 32'(v.exp_range));
  endtask

  // Called #1 after releasing reset on a negedge; counts half-open cycles with busy high.
  task automatic count_busy(output int n, output int ready_bad);
    n = 0;
    ready_bad = 0;
    #1;
    while (busy && n < 3000) begin
      if (req_ready) ready_bad++;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int n, rb;
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.req_ready", 32'(req_ready), 32'd0);

    reset = 1'b1;
    count_busy(n, rb);
    chk("clear.busy_cycles", 32'(n), 32'd1024);
    chk("clear.ready_during_busy", 32'(rb), 32'd0);
    chk("clear.ready_after", 32'(req_ready), 32'd1);
    chk("clear.no_rsp_while_busy", 32'(rsp_valid), 32'd0);
    // req_valid is still held high with lw 0x0: accepted on the first idle edge.
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("clear.first_accept.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("clear.first_accept.rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("clear.rsp_single_pulse", 32'(rsp_valid), 32'd0);

    vecs.push_back(mk("lw_0",        0, 2, 0, 32'h0,    0,            32'h0,        0, 0));
    vecs.push_back(mk("lw_ffc",      0, 2, 0, 32'hFFC,  0,            32'h0,        0, 0));
    vecs.push_back(mk("sw_0",        1, 2, 0, 32'h0,    32'h11223344, 32'h0,        0, 0));
    vecs.push_back(mk("sb_1",        1, 0, 0, 32'h1,    32'h000000AA, 32'h0,        0, 0));
    vecs.push_back(mk("lw_after_sb", 0, 2, 0, 32'h0,    0,            32'h1122AA44, 0, 0));
    vecs.push_back(mk("sh_2",        1, 1, 0, 32'h2,    32'h0000BEEF, 32'h0,        0, 0));
    vecs.push_back(mk("lw_merged",   0, 2, 0, 32'h0,    0,            32'hBEEFAA44, 0, 0));
    vecs.push_back(mk("sw_ext",      1, 2, 0, 32'h0,    32'h80FF7F01, 32'h0,        0, 0));
    vecs.push_back(mk("lb_2",        0, 0, 0, 32'h2,    0,            32'hFFFFFFFF, 0, 0));
    vecs.push_back(mk("lbu_3",       0, 0, 1, 32'h3,    0,            32'h00000080, 0, 0));
    vecs.push_back(mk("lb_1",        0, 0, 0, 32'h1,    0,            32'h0000007F, 0, 0));
    vecs.push_back(mk("lh_0",        0, 1, 0, 32'h0,    0,            32'h00007F01, 0, 0));
    vecs.push_back(mk("lh_2",        0, 1, 0, 32'h2,    0,            32'hFFFF80FF, 0, 0));
    vecs.push_back(mk("lhu_2",       0, 1, 1, 32'h2,    0,            32'h000080FF, 0, 0));
    vecs.push_back(mk("lw_uns_ign",  0, 2, 1, 32'h0,    0,            32'h80FF7F01, 0, 0));
    vecs.push_back(mk("sh_1_align",  1, 1, 0, 32'h1,    32'h00001234, 32'h0,        1, 0));
    vecs.push_back(mk("lw_unchgd",   0, 2, 0, 32'h0,    0,            32'h80FF7F01, 0, 0));
    vecs.push_back(mk("lw_2_align",  0, 2, 0, 32'h2,    0,            32'h0,        1, 0));
    vecs.push_back(mk("lw_range",    0, 2, 0, 32'h1000, 0,            32'h0,        0, 1));
    vecs.push_back(mk("size3",       0, 3, 0, 32'h0,    0,            32'h0,        1, 0));
    vecs.push_back(mk("sw_both",     1, 2, 0, 32'h1001, 32'h12345678, 32'h0,        1, 1));
    vecs.push_back(mk("sw_range",    1, 2, 0, 32'h1000, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mk("lw_noalias",  0, 2, 0, 32'h0,    0,            32'h80FF7F01, 0, 0));
    vecs.push_back(mk("sb_fff",      1, 0, 0, 32'hFFF,  32'h1234565A, 32'h0,        0, 0));
    vecs.push_back(mk("lw_top",      0, 2, 0, 32'hFFC,  0,            32'h5A000000, 0, 0));
    vecs.push_back(mk("lhu_ffe",     0, 1, 1, 32'hFFE,  0,            32'h00005A00, 0, 0));
    vecs.push_back(mk("lh_ffe",      0, 1, 0, 32'hFFE,  0,            32'h00005A00, 0, 0));

    foreach (vecs[i]) issue(vecs[i]);

    // Back-to-back store then load to the same word: RAW returns the new data.
    @(negedge clk);
    drive(mk("b2b_sw", 1, 2, 0, 32'h10, 32'hCAFEF00D, 0, 0, 0));
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b.store_rsp_valid", 32'(rsp_valid), 32'd1);
    drive(mk("b2b_lw", 0, 2, 0, 32'h10, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b.load_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b.load_rdata", rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("b2b.rsp_drops", 32'(rsp_valid), 32'd0);

    // In-flight response dropped by reset, then reset again at sweep cycle 500.
    @(negedge clk);
    drive(mk("inflight", 0, 2, 0, 32'h10, 0, 0, 0, 0));
    req_valid = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    req_valid = 1'b0;
    chk("inflight.rsp_suppressed", 32'(rsp_valid), 32'd0);
    chk("inflight.rdata_cleared", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (500) @(negedge clk);
    chk("midsweep.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    count_busy(n, rb);
    chk("midsweep.busy_cycles", 32'(n), 32'd1024);
    chk("midsweep.ready_during_busy", 32'(rb), 32'd0);
    chk("midsweep.ready_after", 32'(req_ready), 32'd1);

    issue(mk("post_lw_0",  0, 2, 0, 32'h0,   0, 32'h0, 0, 0));
    issue(mk("post_lw_10", 0, 2, 0, 32'h10,  0, 32'h0, 0, 0));
    issue(mk("post_lw_ffc",0, 2, 0, 32'hFFC, 0, 32'h0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_be_mem.md
Name: dm_be_mem

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM serving sb/sh/sw stores and lb/lbu/lh/lhu/lw loads, with byte-lane merge and load sign/zero extension.
- Registered one-cycle response with a valid/ready handshake; alignment and range exception flags.
- Hardware clear sweep after reset. Sits between the execute stage and writeback of the multi-cycle/pipelined core.

Parameters:
- ADDR_BITS, 10, word-address width; DEPTH = 2**ADDR_BITS words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- CLEAR_ON_RESET, 1, 1 = sweep RAM to zero after reset; 0 = skip straight to IDLE.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pc  in  32  PC of the issuing instruction, used for the write trace only.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rdata  out  32  extended load data; 0 for stores and faulted requests.
- exc_align  out  1  valid with rsp_valid; misaligned or illegal size.
- exc_range  out  1  valid with rsp_valid; address outside the window.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - state <- CLEAR, or IDLE if CLEAR_ON_RESET=0; clr_ptr <- 0.
  - rsp_valid, rdata, exc_align, exc_range <- 0.
  - RAM contents are not reset asynchronously.
  - Reset asserted mid-sweep or mid-request restarts the sweep from 0. An in-flight response is dropped.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle RAM[clr_ptr] <- 0, clr_ptr++. When clr_ptr = DEPTH-1 is written, go to IDLE next cycle. Sweep takes exactly DEPTH cycles.
  - busy = (state==CLEAR); req_ready = (state==IDLE).
- Accept: a request is accepted when req_valid && req_ready at a rising edge. The block accepts back-to-back requests every cycle in IDLE, with no backpressure from the response side.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap arithmetic).
  - word index = off[ADDR_BITS+1:2]; lane = off[1:0].
  - exc_range = (off >> 2) >= DEPTH.
- Alignment: exc_align = (size==3) | (size==1 & lane[0]) | (size==2 & lane!=0).
- Faulted request (either exception):
  - No RAM write.
  - rsp_valid pulses with rdata=0 and the flag(s) set.
  - Both flags may be set together.
- Store, good:
  - Byte enables: byte = 1<<lane; half = 2'b11<<lane; word = 4'hF.
  - Lanes are written from wdata replicated: byte into all four lanes, half into both halves.
  - Write commits at the accept edge.
  - Trace: $display("@%h: *%h <= %h", pc, word-aligned byte address, merged full word) at the same edge.
- Load, good:
  - RAM word read at the accept edge and registered.
  - The lane field is selected by lane and extended per req_unsigned (size=2 ignores req_unsigned).
  - rdata is valid in the cycle rsp_valid=1, i.e. the cycle after acceptance; it holds until the next response.
- Latency: exactly 1 cycle from accept to rsp_valid for every request type. rsp_valid is low in cycles without a preceding accept.
- Read-after-write hazard:
  - Load accepted the cycle after a store to the same word returns the merged new data.
  - Load and store are never accepted in the same cycle (single port).
- Address wrap: the index uses only off[ADDR_BITS+1:2] after the range check, so an in-range address never aliases.

Test Plan:
- Reset and clear: drive reset low mid-run, release, hold req_valid=1 → busy=1 and req_ready=0 for exactly 1024 cycles (ADDR_BITS=10), then req_ready=1; lw from 0x0 and from 0xFFC returns 0.
- Byte/half merge: sw 0x0 ← 0x11223344; sb 0x1 ← 0xAA; sh 0x2 ← 0xBEEF; lw 0x0 → 0xBEEFAA44. Trace lines show the merged words 0x1122AA44 and 0xBEEFAA44.
- Extension: with word 0 = 0x80FF7F01: lb 0x2 → 0xFFFFFFFF; lbu 0x3 → 0x00000080; lh 0x0 → 0x00007F01; lh 0x2 → 0xFFFF80FF; lhu 0x2 → 0x000080FF.
- Exceptions: sh 0x1 → exc_align=1 and word unchanged; lw 0x2 → exc_align=1, rdata=0; lw 0x1000 (BASE_ADDR=0) → exc_range=1; req_size=3 → exc_align=1.
- Back-to-back: sw 0x10 ← 0xCAFEF00D, then lw 0x10 on the next cycle → rsp_valid on two consecutive cycles, and the second response rdata=0xCAFEF00D.
- Reset mid-sweep: assert reset at clear cycle 500 for 1 cycle → sweep restarts and busy lasts 1024 cycles after release; an in-flight rsp_valid is suppressed.
